// File: rtl/c64_bus_arbiter.sv
// Two-phase C64 RAM arbiter: VIC owns phi1, CPU owns phi2 unless a badline steal hands phi2 to the VIC.
// Optional steal FSM is enabled by defining C64_BADLINE_STEAL_EN; otherwise the CPU owns every phi2 slot.
module c64_bus_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int VIC_AW    = 14,
  parameter int BA_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic [7:0]        cpu_do,
  input  logic              cpu_we,
  output logic [7:0]        cpu_di,
  output logic              cpu_rdy,
  input  logic [VIC_AW-1:0] vic_ab,
  input  logic              vic_req,
  input  logic              vic_steal_req,
  input  logic [1:0]        vic_bank,
  output logic [7:0]        vic_di,
  output logic              vic_valid,
  output logic              vic_slot,
  output logic [ADDR_W-1:0] mem_ab,
  output logic [7:0]        mem_do,
  output logic              mem_we,
  input  logic [7:0]        mem_di,
  output logic              phase,
  output logic              ba,
  output logic              aec
);

  localparam int CNT_W = (BA_CYCLES > 1) ? $clog2(BA_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BA_CYCLES - 1);

  typedef enum logic [1:0] {RUN = 2'd0, BA_LOW = 2'd1, STOLEN = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ba_q, ba_d, aec_q, aec_d;
  logic [1:0]        t_q, t_d;
  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] mem_ab_q, mem_ab_d;
  logic [7:0]        mem_do_q, mem_do_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        cpu_di_q, cpu_di_d;
  logic              cpu_rdy_q, cpu_rdy_d;
  logic [7:0]        vic_di_q, vic_di_d;
  logic              vic_valid_q, vic_valid_d;
  logic              vic_slot_q, vic_slot_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic              vic_gnt_q, vic_gnt_d;
  logic              steal_s;
  logic              cpu_grant_s;
  logic [ADDR_W-1:0] vic_addr_s;

`ifdef C64_BADLINE_STEAL_EN
  assign steal_s = vic_steal_req;
`else
  logic steal_unused;
  assign steal_unused = vic_steal_req;
  assign steal_s      = 1'b0;
`endif

  // Bank bits are inverted onto the upper address lines, as on the CIA2 port.
  assign vic_addr_s  = ADDR_W'({~vic_bank, vic_ab});
  // A 6502 cannot be halted mid-write, so writes still get the slot while BA is low.
  assign cpu_grant_s = (state_q == RUN) || ((state_q == BA_LOW) && cpu_we);

  // Steal FSM next state, evaluated once per system cycle at the last tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (t_q == 2'd3) begin
      case (state_q)
        RUN: begin
          if (steal_s) begin
            state_d = BA_LOW;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = RUN;
          end
        end
        BA_LOW: begin
          if (!steal_s) begin
            state_d = RUN;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STOLEN;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        STOLEN: begin
          if (!steal_s) begin
            state_d = RUN;
          end else begin
            state_d = STOLEN;
          end
        end
        default: state_d = RUN;
      endcase
    end else begin
      state_d = state_q;
    end
    ba_d  = (state_d == RUN);
    aec_d = (state_d != STOLEN);
  end

  // Slot sequencer: address phase on even ticks, data capture on odd ticks.
  always_comb begin
    t_d         = t_q + 2'd1;
    phase_d     = t_d[1];
    mem_ab_d    = mem_ab_q;
    mem_do_d    = 8'h00;
    mem_we_d    = 1'b0;
    cpu_di_d    = cpu_di_q;
    cpu_rdy_d   = 1'b0;
    vic_di_d    = vic_di_q;
    vic_valid_d = 1'b0;
    vic_slot_d  = vic_slot_q;
    cpu_gnt_d   = 1'b0;
    cpu_rd_d    = 1'b0;
    vic_gnt_d   = 1'b0;
    case (t_q)
      2'd0: begin
        if (vic_req) begin
          mem_ab_d  = vic_addr_s;
          vic_gnt_d = 1'b1;
        end else begin
          vic_gnt_d = 1'b0;
        end
      end
      2'd1: begin
        if (vic_gnt_q) begin
          vic_di_d    = mem_di;
          vic_valid_d = 1'b1;
          vic_slot_d  = 1'b0;
        end else begin
          vic_valid_d = 1'b0;
        end
      end
      2'd2: begin
        if (state_q == STOLEN) begin
          mem_ab_d  = vic_addr_s;
          vic_gnt_d = 1'b1;
        end else if (cpu_grant_s) begin
          mem_ab_d  = cpu_ab;
          cpu_gnt_d = 1'b1;
          cpu_rd_d  = ~cpu_we;
          mem_we_d  = cpu_we;
          mem_do_d  = cpu_we ? cpu_do : 8'h00;
        end else begin
          cpu_gnt_d = 1'b0;
        end
      end
      2'd3: begin
        if (vic_gnt_q) begin
          vic_di_d    = mem_di;
          vic_valid_d = 1'b1;
          vic_slot_d  = 1'b1;
        end else if (cpu_gnt_q) begin
          cpu_rdy_d = 1'b1;
          cpu_di_d  = cpu_rd_q ? mem_di : cpu_di_q;
        end else begin
          cpu_rdy_d = 1'b0;
        end
      end
      default: t_d = 2'd0;
    endcase
  end

  // Steal FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= {CNT_W{1'b0}};
      ba_q    <= 1'b1;
      aec_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ba_q    <= ba_d;
      aec_q   <= aec_d;
    end
  end

  // Datapath and output registers; reset aborts any in-flight write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q         <= 2'd0;
      phase_q     <= 1'b0;
      mem_ab_q    <= {ADDR_W{1'b0}};
      mem_do_q    <= 8'h00;
      mem_we_q    <= 1'b0;
      cpu_di_q    <= 8'h00;
      cpu_rdy_q   <= 1'b0;
      vic_di_q    <= 8'h00;
      vic_valid_q <= 1'b0;
      vic_slot_q  <= 1'b0;
      cpu_gnt_q   <= 1'b0;
      cpu_rd_q    <= 1'b0;
      vic_gnt_q   <= 1'b0;
    end else begin
      t_q         <= t_d;
      phase_q     <= phase_d;
      mem_ab_q    <= mem_ab_d;
      mem_do_q    <= mem_do_d;
      mem_we_q    <= mem_we_d;
      cpu_di_q    <= cpu_di_d;
      cpu_rdy_q   <= cpu_rdy_d;
      vic_di_q    <= vic_di_d;
      vic_valid_q <= vic_valid_d;
      vic_slot_q  <= vic_slot_d;
      cpu_gnt_q   <= cpu_gnt_d;
      cpu_rd_q    <= cpu_rd_d;
      vic_gnt_q   <= vic_gnt_d;
    end
  end

  assign cpu_di    = cpu_di_q;
  assign cpu_rdy   = cpu_rdy_q;
  assign vic_di    = vic_di_q;
  assign vic_valid = vic_valid_q;
  assign vic_slot  = vic_slot_q;
  assign mem_ab    = mem_ab_q;
  assign mem_do    = mem_do_q;
  assign mem_we    = mem_we_q;
  assign phase     = phase_q;
  assign ba        = ba_q;
  assign aec       = aec_q;

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Bench for c64_bus_arbiter: vector table, steal sequences and reset abort, checked through a pulse scoreboard.
// Steal expectations follow whether C64_BADLINE_STEAL_EN is defined for the build.
module tb_c64_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic [13:0] vic_ab;
  logic        vic_req;
  logic        vic_steal_req;
  logic [1:0]  vic_bank;
  logic [7:0]  vic_di;
  logic        vic_valid;
  logic        vic_slot;
  logic [15:0] mem_ab;
  logic [7:0]  mem_do;
  logic        mem_we;
  logic [7:0]  mem_di;
  logic        phase;
  logic        ba;
  logic        aec;

  c64_bus_arbiter #(.ADDR_W(16), .VIC_AW(14), .BA_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_di(cpu_di), .cpu_rdy(cpu_rdy),
    .vic_ab(vic_ab), .vic_req(vic_req), .vic_steal_req(vic_steal_req), .vic_bank(vic_bank),
    .vic_di(vic_di), .vic_valid(vic_valid), .vic_slot(vic_slot),
    .mem_ab(mem_ab), .mem_do(mem_do), .mem_we(mem_we), .mem_di(mem_di),
    .phase(phase), .ba(ba), .aec(aec)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [15:0] a);
    case (a)
      16'h0400: pat = 8'h20;
      16'hC000: pat = 8'hA9;
      16'hFFFF: pat = 8'hE2;
      16'h5000: pat = 8'h3C;
      16'h8000: pat = 8'h81;
      16'h0000: pat = 8'h00;
      16'h0800: pat = 8'h7E;
      default:  pat = a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  // RAM model: preloaded on the first edge, then written by the strobe.
  logic [7:0] ram [0:65535];
  logic       init_done = 1'b0;
  assign mem_di = ram[mem_ab];
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 65536; i++) ram[i] <= pat(16'(i));
      init_done <= 1'b1;
    end else if (mem_we) begin
      ram[mem_ab] <= mem_do;
    end
  end

  typedef struct {
    int         tk;
    logic [7:0] data;
    logic       slot;
    logic       rd;
  } exp_t;

  typedef struct {
    logic        vreq;
    logic [13:0] vab;
    logic [1:0]  bank;
    logic [15:0] cab;
    logic        cwe;
    logic [7:0]  cdo;
    logic [15:0] e_vaddr;
    logic [7:0]  e_vdata;
    logic [7:0]  e_cdata;
  } vec_t;

  exp_t vq[$];
  exp_t cq[$];
  vec_t vecs[6];
  int   total;
  int   bad;
  int   tick_n;
  int   n_rdy;
  int   n_slot1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (tick %0d)", name, act, exp, tick_n);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    while (vq.size() > 0 && vq[0].tk < tick_n) begin
      total++; bad++;
      $display("FAIL vic_valid_missing: got none expected pulse at tick %0d", vq[0].tk);
      void'(vq.pop_front());
    end
    while (cq.size() > 0 && cq[0].tk < tick_n) begin
      total++; bad++;
      $display("FAIL cpu_rdy_missing: got none expected pulse at tick %0d", cq[0].tk);
      void'(cq.pop_front());
    end
    if (vic_valid) begin
      if (vic_slot) n_slot1++;
      if (vq.size() > 0 && vq[0].tk == tick_n) begin
        e = vq.pop_front();
        chk("vic_di", 32'(vic_di), 32'(e.data));
        chk("vic_slot", 32'(vic_slot), 32'(e.slot));
      end else begin
        total++; bad++;
        $display("FAIL vic_valid_unexpected: got 1 expected 0 at tick %0d", tick_n);
      end
    end
    if (cpu_rdy) begin
      n_rdy++;
      if (cq.size() > 0 && cq[0].tk == tick_n) begin
        e = cq.pop_front();
        if (e.rd) chk("cpu_di", 32'(cpu_di), 32'(e.data));
      end else begin
        total++; bad++;
        $display("FAIL cpu_rdy_unexpected: got 1 expected 0 at tick %0d", tick_n);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    tick_n++;
    check_outputs();
  endtask

  task automatic check_reset();
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_ba", 32'(ba), 32'd1);
    chk("rst_aec", 32'(aec), 32'd1);
    chk("rst_cpu_rdy", 32'(cpu_rdy), 32'd0);
    chk("rst_vic_valid", 32'(vic_valid), 32'd0);
    chk("rst_vic_slot", 32'(vic_slot), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_ab", 32'(mem_ab), 32'd0);
    chk("rst_mem_do", 32'(mem_do), 32'd0);
    chk("rst_cpu_di", 32'(cpu_di), 32'd0);
    chk("rst_vic_di", 32'(vic_di), 32'd0);
  endtask

  // One system cycle; mode is the steal state the cycle runs in (0 RUN, 1 BA_LOW, 2 STOLEN).
  task automatic do_cycle(input logic vreq, input logic [13:0] vab, input logic [1:0] bank,
                          input logic [15:0] cab, input logic cwe, input logic [7:0] cdo,
                          input logic steal, input int mode, input logic [15:0] e_vaddr,
                          input logic [7:0] e_vdata, input logic [7:0] e_cdata);
    int   m;
    int   b;
    logic g;
    exp_t e;
    m = mode;
`ifndef C64_BADLINE_STEAL_EN
    m = 0;
`endif
    b = tick_n;
    vic_req = vreq; vic_ab = vab; vic_bank = bank;
    cpu_ab = cab; cpu_we = cwe; cpu_do = cdo; vic_steal_req = steal;
    g = (m == 0) || ((m == 1) && cwe);
    if (vreq) begin
      e.tk = b + 2; e.data = e_vdata; e.slot = 1'b0; e.rd = 1'b1;
      vq.push_back(e);
    end
    if (m == 2) begin
      e.tk = b + 4; e.data = e_vdata; e.slot = 1'b1; e.rd = 1'b1;
      vq.push_back(e);
    end else if (g) begin
      e.tk = b + 4; e.data = e_cdata; e.slot = 1'b0; e.rd = ~cwe;
      cq.push_back(e);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) begin
        chk("phase_phi1", 32'(phase), 32'd0);
        chk("ba", 32'(ba), 32'(m == 0));
        chk("aec", 32'(aec), 32'(m != 2));
        if (vreq) chk("mem_ab_vic", 32'(mem_ab), 32'(e_vaddr));
      end
      if (k == 2) chk("phase_phi2", 32'(phase), 32'd1);
      if (k == 3) begin
        chk("mem_we", 32'(mem_we), 32'(g && cwe));
        if (m == 2) chk("mem_ab_steal", 32'(mem_ab), 32'(e_vaddr));
        else if (g) begin
          chk("mem_ab_cpu", 32'(mem_ab), 32'(cab));
          if (cwe) chk("mem_do", 32'(mem_do), 32'(cdo));
        end
      end
    end
  endtask

  initial begin
    int mode;
    total = 0; bad = 0; tick_n = 0; n_rdy = 0; n_slot1 = 0;
    reset = 1'b1;
    cpu_ab = 16'h0000; cpu_do = 8'h00; cpu_we = 1'b0;
    vic_ab = 14'h0000; vic_req = 1'b0; vic_steal_req = 1'b0; vic_bank = 2'b00;

    vecs[0] = '{1'b1, 14'h0400, 2'b11, 16'hC000, 1'b0, 8'h00, 16'h0400, 8'h20, 8'hA9};
    vecs[1] = '{1'b0, 14'h0000, 2'b11, 16'h0200, 1'b1, 8'h55, 16'h0000, 8'h00, 8'h00};
    vecs[2] = '{1'b1, 14'h3FFF, 2'b00, 16'h0200, 1'b0, 8'h00, 16'hFFFF, 8'hE2, 8'h55};
    vecs[3] = '{1'b1, 14'h1000, 2'b10, 16'h5000, 1'b1, 8'hC3, 16'h5000, 8'h3C, 8'h00};
    vecs[4] = '{1'b1, 14'h1000, 2'b10, 16'hFFFF, 1'b0, 8'h00, 16'h5000, 8'hC3, 8'hE2};
    vecs[5] = '{1'b1, 14'h0000, 2'b01, 16'h0000, 1'b0, 8'h00, 16'h8000, 8'h81, 8'h00};

    repeat (3) @(negedge clk);
    check_reset();
    reset = 1'b0;
    tick_n = 0;

    for (int i = 0; i < 6; i++) begin
      do_cycle(vecs[i].vreq, vecs[i].vab, vecs[i].bank, vecs[i].cab, vecs[i].cwe, vecs[i].cdo,
               1'b0, 0, vecs[i].e_vaddr, vecs[i].e_vdata, vecs[i].e_cdata);
    end
    chk("ram_0200", 32'(ram[16'h0200]), 32'h55);
    chk("ram_5000", 32'(ram[16'h5000]), 32'hC3);

    // Badline steal held for ten cycles against a CPU write stream.
    n_rdy = 0; n_slot1 = 0;
    for (int c = 0; c < 12; c++) begin
      mode = (c == 0) ? 0 : (c <= 3) ? 1 : (c <= 10) ? 2 : 0;
      do_cycle(1'b1, 14'h0800, 2'b11, 16'(16'h0300 + c), 1'b1, 8'(8'h10 + c),
               (c < 10), mode, 16'h0800, 8'h7E, 8'h00);
    end
`ifdef C64_BADLINE_STEAL_EN
    chk("steal_rdy_count", 32'(n_rdy), 32'd5);
    chk("steal_slot1_count", 32'(n_slot1), 32'd7);
    chk("ram_0305_skipped", 32'(ram[16'h0305]), 32'(pat(16'h0305)));
`else
    chk("steal_rdy_count", 32'(n_rdy), 32'd12);
    chk("steal_slot1_count", 32'(n_slot1), 32'd0);
    chk("ram_0305_written", 32'(ram[16'h0305]), 32'h15);
`endif
    chk("ram_0303", 32'(ram[16'h0303]), 32'h13);

    // CPU reads while BA is low, steal withdrawn before AEC drops.
    n_rdy = 0;
    do_cycle(1'b0, 14'h0000, 2'b11, 16'hC000, 1'b0, 8'h00, 1'b1, 0, 16'h0000, 8'h00, 8'hA9);
    do_cycle(1'b0, 14'h0000, 2'b11, 16'h0000, 1'b0, 8'h00, 1'b1, 1, 16'h0000, 8'h00, 8'h00);
    do_cycle(1'b0, 14'h0000, 2'b11, 16'h0000, 1'b0, 8'h00, 1'b0, 1, 16'h0000, 8'h00, 8'h00);
`ifdef C64_BADLINE_STEAL_EN
    chk("cpu_di_held", 32'(cpu_di), 32'hA9);
`else
    chk("cpu_di_held", 32'(cpu_di), 32'h00);
`endif
    do_cycle(1'b0, 14'h0000, 2'b11, 16'h0000, 1'b0, 8'h00, 1'b0, 0, 16'h0000, 8'h00, 8'h00);
`ifdef C64_BADLINE_STEAL_EN
    chk("balow_rdy_count", 32'(n_rdy), 32'd2);
`else
    chk("balow_rdy_count", 32'(n_rdy), 32'd4);
`endif

    // Reset lands while a write strobe is on the bus.
    vic_req = 1'b0; vic_steal_req = 1'b0;
    cpu_ab = 16'h0210; cpu_we = 1'b1; cpu_do = 8'h99;
    tick(); tick(); tick();
    chk("mem_we_before_reset", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("mem_we_abort", 32'(mem_we), 32'd0);
    check_reset();
    @(negedge clk);
    @(negedge clk);
    chk("ram_0210_untouched", 32'(ram[16'h0210]), 32'(pat(16'h0210)));
    chk("cq_empty_at_reset", 32'(cq.size()), 32'd0);
    reset = 1'b0;
    tick_n = 0;
    do_cycle(1'b0, 14'h0000, 2'b11, 16'hC000, 1'b0, 8'h00, 1'b0, 0, 16'h0000, 8'h00, 8'hA9);

    chk("vq_drained", 32'(vq.size()), 32'd0);
    chk("cq_drained", 32'(cq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
